// File: rtl/lab4_pkg.sv
// Shared types and defaults for the two-requester register bank arbiter.
// Holds the FSM state encoding plus the small grant helpers used by the top.
package lab4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_NREG = 4;
    localparam int DEFAULT_W    = 8;

    // One-hot acknowledge vector for the served requester.
    function automatic logic [1:0] grantMask(input logic who);
        return who ? 2'b10 : 2'b01;
    endfunction

    // A lone requester always wins; a tie is broken by the round-robin pointer.
    function automatic logic pickWinner(input logic [1:0] reqBits, input logic pointer);
        logic who;
        who = pointer;
        if (reqBits == 2'b01) begin
            who = 1'b0;
        end else if (reqBits == 2'b10) begin
            who = 1'b1;
        end
        return who;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// Shared register bank: NREG words of enable-gated D flip-flop storage,
// one write port and one combinational read port, cleared by synchronous reset.
module d_flip_flop #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module reg_bank
    import lab4_pkg::*;
#(
    parameter  int NREG = DEFAULT_NREG,
    parameter  int W    = DEFAULT_W,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] words [NREG];

    // Only the addressed word sees its enable; every other word holds.
    for (genvar i = 0; i < NREG; i++) begin : g_word
        d_flip_flop #(
            .W(W)
        ) u_word (
            .clk  (clk),
            .reset(reset),
            .en   (we && (addr == AW'(i))),
            .d    (wdata),
            .q    (words[i])
        );
    end

    assign rdata = words[addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter giving two requesters exclusive, three-cycle access
// (grant, access, acknowledge) to a shared register bank.
module reg_bank_arbiter
    import lab4_pkg::*;
#(
    parameter  int NREG = DEFAULT_NREG,
    parameter  int W    = DEFAULT_W,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    output logic [1:0]    ack,
    output logic [W-1:0]  rdata,
    output logic          busy
);

    state_t        state;
    state_t        nextState;
    logic          pointer;
    logic          grantWinner;
    logic          winner;
    logic          latWe;
    logic [AW-1:0] latAddr;
    logic [W-1:0]  latWdata;
    logic [W-1:0]  capWord;
    logic [W-1:0]  bankRdata;
    logic          bankWe;

    assign grantWinner = pickWinner(req, pointer);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The whole request is frozen at grant time, so later input changes or a
    // dropped req cannot disturb a transaction already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer  <= 1'b0;
            winner   <= 1'b0;
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            capWord  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner   <= grantWinner;
                        latWe    <= grantWinner ? we[1]  : we[0];
                        latAddr  <= grantWinner ? addr1  : addr0;
                        latWdata <= grantWinner ? wdata1 : wdata0;
                    end
                end
                SERVE: begin
                    if (!latWe) begin
                        capWord <= bankRdata;
                    end
                end
                DONE: begin
                    pointer <= ~winner;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        nextState = state;
        ack       = '0;
        rdata     = '0;
        bankWe    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) begin
                    nextState = SERVE;
                end
            end
            SERVE: begin
                bankWe    = latWe;
                nextState = DONE;
            end
            DONE: begin
                ack = grantMask(winner);
                if (!latWe) begin
                    rdata = capWord;
                end
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Bank reset shares the arbiter reset, so an interrupted write never lands.
    reg_bank #(
        .NREG(NREG),
        .W   (W)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .we   (bankWe),
        .addr (latAddr),
        .wdata(latWdata),
        .rdata(bankRdata)
    );

endmodule
